bcd_exc3_seq: RTL and testbench

Multi-digit sequencer that shares one combinational `BCD_Exc_3` converter across `DIGITS` packed BCD digits, one digit per clock. It accepts a packed BCD word on a start strobe and walks the digits LSB-first through the single converter instance. It reassembles the Excess-3 word, flags non-BCD nibbles, and pulses `done`. It sits between the button/switch input stage and the LED display stage of the BCD demo boards.

---
 rtl/bcd_pkg.sv | 19 +
 rtl/BCD_Exc_3.sv | 11 +
 rtl/bcd_exc3_seq.sv | 96 +++++++++
 tb/tb_bcd_exc3_seq.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared definitions for the BCD -> Excess-3 demo blocks: FSM encoding,
// code constants and a digit-validity helper.
package bcd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [3:0] EXC3_OFFSET  = 4'd3;
  localparam logic [3:0] BCD_MAX      = 4'd9;
  localparam logic [3:0] EXC3_INVALID = 4'b0000;

  function automatic logic is_bcd(input logic [3:0] d);
    return d <= BCD_MAX;
  endfunction

endpackage

// File: rtl/BCD_Exc_3.sv
// Single-digit combinational BCD to Excess-3 converter (board-level legacy block).
module BCD_Exc_3
  import bcd_pkg::*;
(
  input  logic [3:0] BTN,
  output logic [3:0] LED
);

  assign LED = BTN + EXC3_OFFSET;

endmodule

// File: rtl/bcd_exc3_seq.sv
// Multi-digit BCD -> Excess-3 sequencer: walks packed digits LSB-first through
// one shared BCD_Exc_3 instance, one digit per clock, and flags non-BCD nibbles.
module bcd_exc3_seq
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   bcd_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   exc3_out,
  output logic [DIGITS-1:0]     err_mask,
  output logic                  err
);

  localparam int            IW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);

  state_t                   state, state_nx;
  logic                     busy_nx, done_nx;
  logic                     accept, last;
  logic [IW-1:0]            idx;
  logic [DIGITS-1:0][3:0]   opnd_q, exc3_q;
  logic [3:0]               dig, dig_exc3;
  logic                     dig_ok;

  // DONE also accepts, so a held start yields a conversion every DIGITS+1 cycles.
  assign accept = start && (state == ST_IDLE || state == ST_DONE);
  assign last   = (idx == LAST);

  // Shared converter path: operand mux -> converter -> nibble write.
  assign dig    = opnd_q[idx];
  assign dig_ok = is_bcd(dig);

  BCD_Exc_3 u_conv (
    .BTN (dig),
    .LED (dig_exc3)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nx;
      busy  <= busy_nx;
      done  <= done_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (start) state_nx = ST_CONV;
      ST_CONV: if (last)  state_nx = ST_DONE;
      ST_DONE: state_nx = start ? ST_CONV : ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state and registered alongside it.
  always_comb begin
    busy_nx = (state_nx != ST_IDLE);
    done_nx = (state_nx == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opnd_q   <= '0;
      exc3_q   <= '0;
      err_mask <= '0;
      err      <= 1'b0;
      idx      <= '0;
    end else if (accept) begin
      opnd_q   <= bcd_in;
      exc3_q   <= '0;
      err_mask <= '0;
      err      <= 1'b0;
      idx      <= '0;
    end else if (state == ST_CONV) begin
      exc3_q[idx]   <= dig_ok ? dig_exc3 : EXC3_INVALID;
      err_mask[idx] <= ~dig_ok;
      if (last)
        err <= (|err_mask) | ~dig_ok;
      else
        idx <= idx + 1'b1;
    end
  end

  assign exc3_out = exc3_q;

endmodule

// File: tb/tb_bcd_exc3_seq.sv
// Directed bench for bcd_exc3_seq (DIGITS=4) with hand-computed expectations.
module tb_bcd_exc3_seq;

  localparam int DIGITS = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] bcd_in;
  logic        busy, done, err;
  logic [15:0] exc3_out;
  logic [3:0]  err_mask;

  int n_tests = 0;
  int n_fail  = 0;

  bcd_exc3_seq #(.DIGITS(DIGITS)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .bcd_in   (bcd_in),
    .busy     (busy),
    .done     (done),
    .exc3_out (exc3_out),
    .err_mask (err_mask),
    .err      (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Counts negedges from k0 until done is seen; returns 99 on timeout.
  task automatic wait_done(input int k0, output int lat);
    lat = 99;
    for (int k = k0 + 1; k <= k0 + 12; k++) begin
      @(negedge clk);
      if (done) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic run_conv(input string tag, input logic [15:0] bcd,
                          input logic [15:0] exp, input logic [3:0] m, input logic e);
    int lat;
    @(negedge clk);
    start  = 1'b1;
    bcd_in = bcd;
    @(negedge clk);
    start  = 1'b0;
    bcd_in = 16'hFFFF;
    chk({tag, ".busy"}, busy, 1);
    wait_done(0, lat);
    chk({tag, ".lat"},  lat, 4);
    chk({tag, ".exc3"}, exc3_out, exp);
    chk({tag, ".mask"}, err_mask, m);
    chk({tag, ".err"},  err, e);
    chk({tag, ".busy_dn"}, busy, 1);
    @(negedge clk);
    chk({tag, ".done_off"}, done, 0);
    chk({tag, ".idle"},     busy, 0);
    chk({tag, ".hold"},     exc3_out, exp);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    rst_n  = 1'b0;
    start  = 1'b1;
    bcd_in = 16'hA5A5;
    repeat (3) @(negedge clk);
    chk("rst.busy", busy, 0);
    chk("rst.done", done, 0);
    chk("rst.exc3", exc3_out, 0);
    chk("rst.mask", err_mask, 0);
    chk("rst.err",  err, 0);
    rst_n = 1'b1;
    start = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("rst.nodone", done, 0);
    end

    run_conv("nom",  16'h1234, 16'h4567, 4'b0000, 1'b0);
    run_conv("b9090", 16'h9090, 16'hC3C3, 4'b0000, 1'b0);
    run_conv("b0000", 16'h0000, 16'h3333, 4'b0000, 1'b0);
    run_conv("inval", 16'hA1F9, 16'h040C, 4'b1010, 1'b1);

    // start pulsed mid-conversion with different data must be ignored
    @(negedge clk);
    start  = 1'b1;
    bcd_in = 16'h1234;
    @(negedge clk);
    start  = 1'b0;
    @(negedge clk);
    start  = 1'b1;
    bcd_in = 16'h9999;
    @(negedge clk);
    start  = 1'b0;
    wait_done(2, lat);
    chk("ign.lat",  lat, 4);
    chk("ign.exc3", exc3_out, 16'h4567);
    chk("ign.mask", err_mask, 0);
    @(negedge clk);

    // start held high: back-to-back conversions every 5 cycles
    start  = 1'b1;
    bcd_in = 16'h1234;
    @(negedge clk);
    bcd_in = 16'h9090;
    chk("b2b.busy", busy, 1);
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      chk("b2b.done", done, (k % 5) == 4);
      if (k == 4)  chk("b2b.r0", exc3_out, 16'h4567);
      if (k == 5)  bcd_in = 16'h0000;
      if (k == 9)  chk("b2b.r1", exc3_out, 16'hC3C3);
      if (k == 14) chk("b2b.r2", exc3_out, 16'h3333);
    end
    start = 1'b0;
    @(negedge clk);
    chk("b2b.idle", busy, 0);

    // reset after two digits of 5678
    start  = 1'b1;
    bcd_in = 16'h5678;
    @(negedge clk);
    start  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("mid.part", exc3_out, 16'h00AB);
    rst_n = 1'b0;
    #1;
    chk("mid.busy", busy, 0);
    chk("mid.done", done, 0);
    chk("mid.exc3", exc3_out, 0);
    chk("mid.mask", err_mask, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      chk("mid.nodone", done, 0);
    end
    run_conv("post", 16'h0001, 16'h3334, 4'b0000, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
